// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM states, register map
// offsets and STATUS bit positions.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 5;

    // A divisor of zero would stall the bit timer, so it is stored as 1.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous first-word-fallthrough FIFO used as the UART transmit buffer.
// The full check uses the pre-pop count, so a push while full is dropped
// even if a pop happens in the same cycle.
module uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the storage array is deliberately not reset; the count guards
    // every read, and leaving it out keeps the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, byte FIFO, bit timer
// and frame FSM. Raises irq_txempty once the FIFO and shifter have drained.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  io_addr_3_2,
    input  logic        io_we,
    input  logic [31:0] io_din,
    output logic [31:0] io_dout,
    output logic        uart_txd,
    output logic        irq_txempty
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   state, state_d;
    logic [15:0] timer, timer_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic [7:0]  shreg, shreg_d;
    logic        txd_d;
    logic [15:0] div_reg;
    logic        irq_en;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic          bit_end;
    logic          unused_din;

    assign fifo_push   = io_we && (io_addr_3_2 == REG_TXDATA);
    assign busy        = (state != ST_IDLE);
    assign bit_end     = (timer == 16'd0);
    assign irq_txempty = irq_en & fifo_empty & ~busy;
    assign unused_din  = ^io_din[31:16];

    uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (io_din[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Writable registers: baud divisor and interrupt enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= DEFAULT_DIV;
            irq_en  <= 1'b0;
        end else if (io_we) begin
            case (io_addr_3_2)
                REG_BAUDDIV: div_reg <= clamp_div(io_din[15:0]);
                REG_CTRL:    irq_en  <= io_din[0];
                default:     ;
            endcase
        end
    end

    // Frame state, bit timer, shifter and the registered serial output.
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            bit_idx  <= bit_idx_d;
            shreg    <= shreg_d;
            uart_txd <= txd_d;
        end
    end

    // Next-state logic; the divisor is sampled only when a bit starts, so a
    // mid-frame BAUDDIV write leaves the current bit length unchanged.
    // NOTE: every output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d   = state;
        timer_d   = (timer == 16'd0) ? 16'd0 : timer - 16'd1;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    state_d  = ST_START;
                    timer_d  = div_reg - 16'd1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    timer_d   = div_reg - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_d = div_reg - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shreg_d   = {1'b0, shreg[7:1]};
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        state_d  = ST_START;
                        timer_d  = div_reg - 16'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shreg_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // Register read mux; reads have no side effects.
    always_comb begin
        io_dout = 32'd0;
        case (io_addr_3_2)
            REG_STATUS: begin
                io_dout[STAT_FULL]  = fifo_full;
                io_dout[STAT_EMPTY] = fifo_empty;
                io_dout[STAT_BUSY]  = busy;
                io_dout[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
            end
            REG_BAUDDIV: io_dout[15:0] = div_reg;
            REG_CTRL:    io_dout[0]    = irq_en;
            default:     io_dout = 32'd0;
        endcase
    end

endmodule
